// File: rtl/word_uart_serializer_if.sv
// ---------------------------------------------------------------------------
// word_uart_serializer_if
// Byte-wide handshake between the word serializer and the UART transmitter.
//   tx_start : serializer -> TX, start strobe for the byte on tx_data
//   tx_data  : serializer -> TX, byte to transmit
//   tx_done  : TX -> serializer, 1 = transmitter idle/ready, 0 = transmitting
// master = serializer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface word_uart_serializer_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_done
  );
endinterface

// File: rtl/word_uart_serializer.sv
// ---------------------------------------------------------------------------
// word_uart_serializer
// Serialises a DATA_W-bit result word into bytes for a byte-wide UART
// transmitter. One transmission per rising edge of trigger, optional header
// byte, selectable byte order, and a timeout flag for a transmitter that
// never acknowledges a start strobe.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   trigger : level; a 0->1 transition requests a transmission
//   word_in : word captured on the accepted trigger edge
//   tx      : TX handshake (tx_start / tx_data out, tx_done in)
//   busy    : high from accepted trigger until the sequence ends
//   done    : one-cycle pulse on successful completion
//   err     : sticky timeout flag, cleared by rst or the next accepted trigger
// ---------------------------------------------------------------------------
module word_uart_serializer #(
  parameter int         DATA_W      = 16,
  parameter bit         MSB_FIRST   = 1'b1,
  parameter bit         HEADER_EN   = 1'b0,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter int         ACK_TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [DATA_W-1:0]     word_in,
  word_uart_serializer_if.master tx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int NTOT   = NBYTES + (HEADER_EN ? 1 : 0);
  localparam int CW     = $clog2(NTOT + 1);
  localparam int TW     = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, STROBE, ACK} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next, shift_adv;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [TW-1:0]     tmo_reg, tmo_next, tmo_inc;
  logic              trig_q_reg;
  logic              tx_start_reg, tx_start_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  logic trig_edge, hdr_step, last_byte, tmo_hit;

  // Byte that goes out next from a given shift-register image.
  function automatic logic [7:0] lead_byte(input logic [DATA_W-1:0] d);
    if (MSB_FIRST) return d[DATA_W-1 -: 8];
    else           return d[7:0];
  endfunction

  // Shift the register one byte lane towards the output end; built lane by
  // lane so an 8-bit word (single lane) needs no special casing.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shift_adv[gi*8 +: 8] = 8'h00;
        end else begin : g_move
          assign shift_adv[gi*8 +: 8] = shift_reg[(gi-1)*8 +: 8];
        end
      end else begin : g_lsb
        if (gi == NBYTES - 1) begin : g_fill
          assign shift_adv[gi*8 +: 8] = 8'h00;
        end else begin : g_move
          assign shift_adv[gi*8 +: 8] = shift_reg[(gi+1)*8 +: 8];
        end
      end
    end
  endgenerate

  assign trig_edge = trigger & ~trig_q_reg;
  // Counter still at its load value means the header byte is the current one.
  assign hdr_step  = HEADER_EN && (cnt_reg == CW'(NTOT));
  assign last_byte = (cnt_reg == CW'(1));
  assign tmo_inc   = tmo_reg + TW'(1);
  assign tmo_hit   = (tmo_inc == TW'(ACK_TIMEOUT));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      tmo_reg      <= '0;
      trig_q_reg   <= 1'b0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      cnt_reg      <= cnt_next;
      tmo_reg      <= tmo_next;
      trig_q_reg   <= trigger;
      tx_start_reg <= tx_start_next;
      tx_data_reg  <= tx_data_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (trig_edge) state_next = WAIT_RDY;
      WAIT_RDY: if (tx.tx_done) state_next = STROBE;
      STROBE: begin
        if (!tx.tx_done)  state_next = ACK;
        else if (tmo_hit) state_next = IDLE;
      end
      ACK:      if (tx.tx_done) state_next = last_byte ? IDLE : STROBE;
      default:  state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    shift_next    = shift_reg;
    cnt_next      = cnt_reg;
    tmo_next      = tmo_reg;
    tx_start_next = tx_start_reg;
    tx_data_next  = tx_data_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    err_next      = err_reg;
    case (state_reg)
      IDLE: begin
        tx_start_next = 1'b0;
        tx_data_next  = 8'h00;
        busy_next     = 1'b0;
        if (trig_edge) begin
          shift_next = word_in;
          cnt_next   = CW'(NTOT);
          err_next   = 1'b0;
          busy_next  = 1'b1;
        end
      end
      WAIT_RDY: begin
        if (tx.tx_done) begin
          tx_start_next = 1'b1;
          tx_data_next  = hdr_step ? HEADER_BYTE : lead_byte(shift_reg);
          tmo_next      = '0;
        end
      end
      STROBE: begin
        if (!tx.tx_done) begin
          tx_start_next = 1'b0;
        end else begin
          tmo_next = tmo_inc;
          if (tmo_hit) begin
            tx_start_next = 1'b0;
            tx_data_next  = 8'h00;
            busy_next     = 1'b0;
            err_next      = 1'b1;
          end
        end
      end
      ACK: begin
        if (tx.tx_done) begin
          if (last_byte) begin
            tx_data_next = 8'h00;
            busy_next    = 1'b0;
            done_next    = 1'b1;
          end else begin
            cnt_next      = cnt_reg - CW'(1);
            // Leaving the header step: first data byte is still in place.
            shift_next    = hdr_step ? shift_reg : shift_adv;
            tx_data_next  = lead_byte(shift_next);
            tx_start_next = 1'b1;
            tmo_next      = '0;
          end
        end
      end
      default: begin
        tx_start_next = 1'b0;
        tx_data_next  = 8'h00;
        busy_next     = 1'b0;
        err_next      = 1'b0;
      end
    endcase
  end

  assign tx.tx_start = tx_start_reg;
  assign tx.tx_data  = tx_data_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_word_uart_serializer.sv
// ---------------------------------------------------------------------------
// tb_word_uart_serializer
// Two serializer instances (16-bit MSB-first without header, 32-bit
// LSB-first with header), each talking to a small behavioural transmitter.
// Observed byte streams are compared with byte lists computed from the word.
// ---------------------------------------------------------------------------
module tb_word_uart_serializer;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        trig16, trig32;
  logic [15:0] w16;
  logic [31:0] w32;
  logic        busy16, done16, err16;
  logic        busy32, done32, err32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  word_uart_serializer_if if16 ();
  word_uart_serializer_if if32 ();

  word_uart_serializer #(
    .DATA_W(16), .MSB_FIRST(1'b1), .HEADER_EN(1'b0),
    .HEADER_BYTE(8'hA5), .ACK_TIMEOUT(15)
  ) dut16 (
    .clk(clk), .rst(rst), .trigger(trig16), .word_in(w16),
    .tx(if16.master), .busy(busy16), .done(done16), .err(err16)
  );

  word_uart_serializer #(
    .DATA_W(32), .MSB_FIRST(1'b0), .HEADER_EN(1'b1),
    .HEADER_BYTE(8'hA5), .ACK_TIMEOUT(15)
  ) dut32 (
    .clk(clk), .rst(rst), .trigger(trig32), .word_in(w32),
    .tx(if32.master), .busy(busy32), .done(done32), .err(err32)
  );

  // Transmitter models. mode: 0 = normal (drop tx_done one cycle after a
  // start, 10-cycle frame), 1 = tx_done stuck high, 2 = tx_done held low.
  int mode16 = 0, mode32 = 0;
  int frame16 = 0, frame32 = 0;

  always @(posedge clk) begin
    if (mode16 == 1) begin
      if16.tx_done <= 1'b1; frame16 <= 0;
    end else if (mode16 == 2) begin
      if16.tx_done <= 1'b0; frame16 <= 0;
    end else if (frame16 > 0) begin
      frame16 <= frame16 - 1;
      if (frame16 == 1) if16.tx_done <= 1'b1;
    end else if (if16.tx_done && if16.tx_start) begin
      if16.tx_done <= 1'b0; frame16 <= 10;
    end else begin
      if16.tx_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (mode32 == 1) begin
      if32.tx_done <= 1'b1; frame32 <= 0;
    end else if (mode32 == 2) begin
      if32.tx_done <= 1'b0; frame32 <= 0;
    end else if (frame32 > 0) begin
      frame32 <= frame32 - 1;
      if (frame32 == 1) if32.tx_done <= 1'b1;
    end else if (if32.tx_done && if32.tx_start) begin
      if32.tx_done <= 1'b0; frame32 <= 10;
    end else begin
      if32.tx_done <= 1'b1;
    end
  end

  // Monitor: bytes captured on each tx_start rising edge, plus counters.
  byte_q_t q16, q32;
  int   pulses16 = 0, high16 = 0, dones16 = 0;
  int   pulses32 = 0, dones32 = 0;
  logic prev16 = 1'b0, prev32 = 1'b0;

  always @(negedge clk) begin
    if (if16.tx_start === 1'b1 && !prev16) begin
      q16.push_back(if16.tx_data); pulses16++;
    end
    if (if16.tx_start === 1'b1) high16++;
    if (done16 === 1'b1) dones16++;
    prev16 = (if16.tx_start === 1'b1);
    if (if32.tx_start === 1'b1 && !prev32) begin
      q32.push_back(if32.tx_data); pulses32++;
    end
    if (done32 === 1'b1) dones32++;
    prev32 = (if32.tx_start === 1'b1);
  end

  // Reference byte streams
  function automatic byte_q_t model16(input logic [15:0] w);
    byte_q_t q;
    for (int i = 1; i >= 0; i--) q.push_back(8'((w >> (8 * i)) & 16'h00FF));
    return q;
  endfunction

  function automatic byte_q_t model32(input logic [31:0] w);
    byte_q_t q;
    q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) q.push_back(8'((w >> (8 * i)) & 32'h0000_00FF));
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire16(input logic [15:0] w);
    w16 = w; trig16 = 1'b1; tick(); trig16 = 1'b0;
  endtask

  task automatic fire32(input logic [31:0] w);
    w32 = w; trig32 = 1'b1; tick(); trig32 = 1'b0;
  endtask

  task automatic wait_idle16(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!busy16) begin timed_out = 1'b0; break; end
      tick();
    end
    tick(); tick();
  endtask

  task automatic wait_idle32(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!busy32) begin timed_out = 1'b0; break; end
      tick();
    end
    tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; trig16 = 1'b0; trig32 = 1'b0; w16 = '0; w32 = '0;
    repeat (3) tick();
    n_checks++; if (if16.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start16 got %b want 0", if16.tx_start); end
    n_checks++; if (if16.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data16 got %h want 00", if16.tx_data); end
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy16 got %b want 0", busy16); end
    n_checks++; if (done16 !== 1'b0) begin n_fail++; $display("FAIL reset_done16 got %b want 0", done16); end
    n_checks++; if (err16 !== 1'b0) begin n_fail++; $display("FAIL reset_err16 got %b want 0", err16); end
    n_checks++; if (if32.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start32 got %b want 0", if32.tx_start); end
    n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL reset_busy32 got %b want 0", busy32); end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic16();
    for (int t = 0; t < 4; t++) begin
      logic [15:0] w;
      byte_q_t exp;
      int p0, d0, qs;
      bit to;
      w = (t == 0) ? 16'hBEEF : 16'($urandom);
      exp = model16(w);
      p0 = pulses16; d0 = dones16; qs = q16.size();
      fire16(w);
      wait_idle16(to);
      $display("txn dut16 word=%h bytes=%0d", w, pulses16 - p0);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic16_timeout got busy stuck want idle"); end
      n_checks++; if (pulses16 - p0 !== 2) begin n_fail++; $display("FAIL basic16_pulses got %0d want 2", pulses16 - p0); end
      n_checks++; if (dones16 - d0 !== 1) begin n_fail++; $display("FAIL basic16_done got %0d want 1", dones16 - d0); end
      n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL basic16_busy got %b want 0", busy16); end
      n_checks++; if (err16 !== 1'b0) begin n_fail++; $display("FAIL basic16_err got %b want 0", err16); end
      for (int i = 0; i < 2; i++) begin
        logic [7:0] got;
        got = (q16.size() > qs + i) ? q16[qs + i] : 8'hxx;
        n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL basic16_byte%0d got %h want %h", i, got, exp[i]); end
      end
    end
  endtask

  task automatic test_header32();
    for (int t = 0; t < 3; t++) begin
      logic [31:0] w;
      byte_q_t exp;
      int p0, d0, qs;
      bit to;
      w = (t == 0) ? 32'h1122_3344 : $urandom;
      exp = model32(w);
      p0 = pulses32; d0 = dones32; qs = q32.size();
      fire32(w);
      wait_idle32(to);
      $display("txn dut32 word=%h bytes=%0d", w, pulses32 - p0);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL hdr32_timeout got busy stuck want idle"); end
      n_checks++; if (pulses32 - p0 !== 5) begin n_fail++; $display("FAIL hdr32_pulses got %0d want 5", pulses32 - p0); end
      n_checks++; if (dones32 - d0 !== 1) begin n_fail++; $display("FAIL hdr32_done got %0d want 1", dones32 - d0); end
      n_checks++; if (err32 !== 1'b0) begin n_fail++; $display("FAIL hdr32_err got %b want 0", err32); end
      for (int i = 0; i < 5; i++) begin
        logic [7:0] got;
        got = (q32.size() > qs + i) ? q32[qs + i] : 8'hxx;
        n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL hdr32_byte%0d got %h want %h", i, got, exp[i]); end
      end
    end
  endtask

  task automatic test_held_trigger();
    logic [15:0] w;
    byte_q_t exp;
    int p0, d0, qs;
    w = 16'($urandom);
    exp = model16(w);
    p0 = pulses16; d0 = dones16; qs = q16.size();
    w16 = w; trig16 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 6) trig16 = 1'b0;
      if (i == 7) trig16 = 1'b1;
      if (i == 10) w16 = ~w;
    end
    trig16 = 1'b0;
    repeat (3) tick();
    $display("txn dut16 held word=%h bytes=%0d", w, pulses16 - p0);
    n_checks++; if (pulses16 - p0 !== 2) begin n_fail++; $display("FAIL held_pulses got %0d want 2", pulses16 - p0); end
    n_checks++; if (dones16 - d0 !== 1) begin n_fail++; $display("FAIL held_done got %0d want 1", dones16 - d0); end
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL held_busy got %b want 0", busy16); end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] got;
      got = (q16.size() > qs + i) ? q16[qs + i] : 8'hxx;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL held_byte%0d got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] w;
    byte_q_t exp;
    int p0, d0, h0, qs;
    bit to;
    mode16 = 1; tick();
    p0 = pulses16; d0 = dones16; h0 = high16;
    fire16(16'($urandom));
    wait_idle16(to);
    $display("txn dut16 timeout start_cycles=%0d", high16 - h0);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL tmo_wait got busy stuck want idle"); end
    n_checks++; if (high16 - h0 !== 15) begin n_fail++; $display("FAIL tmo_start_cycles got %0d want 15", high16 - h0); end
    n_checks++; if (err16 !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b want 1", err16); end
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL tmo_busy got %b want 0", busy16); end
    n_checks++; if (dones16 - d0 !== 0) begin n_fail++; $display("FAIL tmo_done got %0d want 0", dones16 - d0); end
    n_checks++; if (pulses16 - p0 !== 1) begin n_fail++; $display("FAIL tmo_pulses got %0d want 1", pulses16 - p0); end
    mode16 = 0; repeat (2) tick();
    w = 16'($urandom);
    exp = model16(w);
    p0 = pulses16; d0 = dones16; qs = q16.size();
    fire16(w);
    n_checks++; if (err16 !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear got %b want 0", err16); end
    wait_idle16(to);
    $display("txn dut16 after_timeout word=%h bytes=%0d", w, pulses16 - p0);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL tmo_retry_wait got busy stuck want idle"); end
    n_checks++; if (dones16 - d0 !== 1) begin n_fail++; $display("FAIL tmo_retry_done got %0d want 1", dones16 - d0); end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] got;
      got = (q16.size() > qs + i) ? q16[qs + i] : 8'hxx;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL tmo_retry_byte%0d got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    byte_q_t exp;
    int p0, d0, qs;
    bit found, to;
    p0 = pulses16;
    fire16(16'($urandom));
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pulses16 - p0 == 1 && if16.tx_start === 1'b0 && busy16 === 1'b1) begin
        found = 1'b1; break;
      end
      tick();
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_ack got not_found want found"); end
    rst = 1'b1; tick();
    n_checks++; if (if16.tx_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_start got %b want 0", if16.tx_start); end
    n_checks++; if (if16.tx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx_data got %h want 00", if16.tx_data); end
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy16); end
    rst = 1'b0;
    repeat (15) tick();
    n_checks++; if (pulses16 - p0 !== 1) begin n_fail++; $display("FAIL rstmid_no_restart got %0d want 1", pulses16 - p0); end
    w = 16'($urandom);
    exp = model16(w);
    p0 = pulses16; d0 = dones16; qs = q16.size();
    fire16(w);
    wait_idle16(to);
    $display("txn dut16 after_reset word=%h bytes=%0d", w, pulses16 - p0);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rstmid_wait got busy stuck want idle"); end
    n_checks++; if (pulses16 - p0 !== 2) begin n_fail++; $display("FAIL rstmid_pulses got %0d want 2", pulses16 - p0); end
    n_checks++; if (dones16 - d0 !== 1) begin n_fail++; $display("FAIL rstmid_done got %0d want 1", dones16 - d0); end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] got;
      got = (q16.size() > qs + i) ? q16[qs + i] : 8'hxx;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL rstmid_byte%0d got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_tx_busy();
    logic [15:0] w;
    byte_q_t exp;
    int p0, d0, qs;
    bit to;
    mode16 = 2; tick();
    w = 16'($urandom);
    exp = model16(w);
    p0 = pulses16; d0 = dones16; qs = q16.size();
    fire16(w);
    repeat (20) tick();
    n_checks++; if (pulses16 - p0 !== 0) begin n_fail++; $display("FAIL txbusy_no_start got %0d want 0", pulses16 - p0); end
    n_checks++; if (if16.tx_start !== 1'b0) begin n_fail++; $display("FAIL txbusy_tx_start got %b want 0", if16.tx_start); end
    n_checks++; if (busy16 !== 1'b1) begin n_fail++; $display("FAIL txbusy_busy got %b want 1", busy16); end
    mode16 = 0;
    wait_idle16(to);
    $display("txn dut16 tx_busy word=%h bytes=%0d", w, pulses16 - p0);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL txbusy_wait got busy stuck want idle"); end
    n_checks++; if (pulses16 - p0 !== 2) begin n_fail++; $display("FAIL txbusy_pulses got %0d want 2", pulses16 - p0); end
    n_checks++; if (dones16 - d0 !== 1) begin n_fail++; $display("FAIL txbusy_done got %0d want 1", dones16 - d0); end
    n_checks++; if (err16 !== 1'b0) begin n_fail++; $display("FAIL txbusy_err got %b want 0", err16); end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] got;
      got = (q16.size() > qs + i) ? q16[qs + i] : 8'hxx;
      n_checks++; if (got !== exp[i]) begin n_fail++; $display("FAIL txbusy_byte%0d got %h want %h", i, got, exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic16();
    test_header32();
    test_held_trigger();
    test_timeout();
    test_reset_mid();
    test_tx_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no_finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/word_uart_serializer.md
Name: word_uart_serializer

Overview:
- Generalised successor to the processor-halt result dump: serialises a DATA_W-bit result word into bytes for the byte-wide UART transmitter (tx_start / d_in / tx_done handshake).
- Optional header byte; configurable byte order; one transmission per rising edge of the trigger.
- Detects a transmitter that never acknowledges (timeout) and flags it.
- Sits between the CPU datapath (accumulator / halt indication) and the TX block, replacing the hand-written 2-byte output FSM in the top level.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8, range 8..64. NBYTES = DATA_W/8.
- MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant first.
- HEADER_EN, 0, 1 = send HEADER_BYTE before the data bytes.
- HEADER_BYTE, 8'hA5, header value.
- ACK_TIMEOUT, 1023, max cycles in STROBE waiting for tx_done to fall; width = clog2(ACK_TIMEOUT+1).

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- trigger, in, 1, level; a rising edge (trigger=1, previous sample 0) requests a transmission.
- word_in, in, DATA_W, word captured on the accepted trigger edge.
- tx_done, in, 1, from TX: 1 = transmitter idle/ready, 0 = transmitting.
- tx_start, out, 1, start strobe to TX (registered).
- tx_data, out, 8, byte to TX (registered), stable while tx_start=1 and until tx_done rises.
- busy, out, 1, 1 from accepted trigger until sequence end.
- done, out, 1, one-cycle pulse on successful completion.
- err, out, 1, sticky timeout flag; cleared by rst or next accepted trigger.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; tx_start=0, tx_data=0, busy=0, done=0, err=0; shift reg, counters, trig_q=0. Reset mid-sequence aborts immediately; no further tx_start.
- trig_q <= trigger every cycle in all states; edges arriving while busy are ignored (not queued). A level held through completion does not retrigger.
- Total bytes NTOT = NBYTES + HEADER_EN; byte counter loaded with NTOT.
- States:
  - IDLE: busy=0, tx_data=0. On trigger edge: latch word_in into shift reg, err<=0, busy<=1, load counter -> WAIT_RDY.
  - WAIT_RDY: hold; when tx_done=1 -> STROBE with tx_start<=1, tx_data<=current byte (header first if enabled, else per MSB_FIRST), timeout counter<=0.
  - STROBE: tx_start=1, tx_data held. If tx_done=0 -> ACK, tx_start<=0. Else increment timeout; when it reaches ACK_TIMEOUT -> IDLE, err<=1, tx_start<=0, busy<=0, done stays 0.
  - ACK: tx_start=0, tx_data held. When tx_done=1: if counter=1 -> IDLE, done<=1 for one cycle, busy<=0; else decrement counter, shift reg by 8 (left if MSB_FIRST, right otherwise; header step does not shift), -> STROBE with next byte and tx_start<=1.
- Latency: trigger edge sampled at edge E0; with tx_done=1, tx_start high after E1. Each byte takes ≥2 cycles plus TX time.
- Simultaneous events:
  - Trigger edge with rst=1: reset wins.
  - tx_done already 0 when entering STROBE: that byte is acknowledged at the next edge; TX is responsible for not starting early.
- word_in changes after capture have no effect on the sequence in progress.
- default/illegal state -> IDLE with reset output values.

Test Plan:
- DATA_W=16, MSB_FIRST=1, word_in=16'hBEEF, TX model (drops tx_done 1 cycle after tx_start, 10-cycle frame) -> bytes 8'hBE then 8'hEF; exactly 2 tx_start pulses; done pulse once; busy low afterwards.
- DATA_W=32, MSB_FIRST=0, HEADER_EN=1, word_in=32'h11223344 -> byte sequence A5, 44, 33, 22, 11; err=0.
- trigger held high 200 cycles, plus a second edge while busy -> exactly one sequence transmitted; word_in changes mid-sequence don't alter bytes.
- tx_done stuck at 1, ACK_TIMEOUT=15 -> tx_start high exactly 15 cycles; then err=1, busy=0, no done. Next trigger clears err.
- rst asserted while in ACK of byte 1 -> next cycle tx_start=0, tx_data=0, busy=0; new trigger restarts from first byte.
- tx_done low (TX busy) at trigger -> stays in WAIT_RDY with tx_start=0 until tx_done=1, then proceeds normally.
